// File: rtl/uart_boot_loader_pkg.sv
// uart_boot_pkg: shared constants for the UART boot loader slice.
// Latency: n/a (declarations only). Backpressure: n/a.
// Contents: FSM state encodings, sync byte, bytes per memory word.
package uart_boot_pkg;

  typedef logic [2:0] state_t;

  // Kept as plain constants so the encoding stays stable across tools.
  localparam state_t IDLE   = 3'd0;
  localparam state_t CNT_LO = 3'd1;
  localparam state_t CNT_HI = 3'd2;
  localparam state_t DATA   = 3'd3;
  localparam state_t WRITE  = 3'd4;
  localparam state_t CHK    = 3'd5;
  localparam state_t RUN    = 3'd6;
  localparam state_t ERROR  = 3'd7;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam int         WORD_BYTES = 4;

endpackage

// File: rtl/uart_boot_loader_if.sv
// uart_boot_loader_if: one data-memory write port (address, data, byte mask).
// Latency: none, plain wires. Backpressure: none, a write is taken when wMask != 0.
// Modports: master drives the port, slave observes it.
interface uart_boot_loader_if;
  logic [31:0] wAddr;
  logic [31:0] wData;
  logic [3:0]  wMask;

  modport master (output wAddr, output wData, output wMask);
  modport slave  (input  wAddr, input  wData, input  wMask);
endinterface

// File: rtl/uart_boot_loader_rx.sv
// uart_rx_byte: 8N1 UART receiver with 2-flop synchronizer and mid-bit sampling.
// Latency: byte_valid_o/frame_err_o pulse ~3 cycles after the stop bit's mid-point sample time.
// Backpressure: none; each pulse lasts one cycle and must be consumed then.
// Ports: clk_i, reset_i (async active-low), rxd_i (idle high) -> byte_o, byte_valid_o, frame_err_o.
module uart_rx_byte
  import uart_boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 26
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rxd_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] HUNT  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] BITS  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic          rxMeta, rxSync, rxPrev;
  logic [1:0]    phase;
  logic [CW-1:0] cnt;
  logic [2:0]    bitIdx;
  logic [7:0]    shiftReg;

  assign byte_o = shiftReg;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rxMeta       <= 1'b1;
      rxSync       <= 1'b1;
      rxPrev       <= 1'b1;
      phase        <= HUNT;
      cnt          <= '0;
      bitIdx       <= '0;
      shiftReg     <= '0;
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      rxMeta       <= rxd_i;
      rxSync       <= rxMeta;
      rxPrev       <= rxSync;
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      case (phase)
        HUNT: begin
          if (rxPrev && !rxSync) begin
            phase <= START;
            cnt   <= '0;
          end
        end
        START: begin
          // A line that is high again at half a bit was only a glitch.
          if (cnt == HALF_LAST) begin
            cnt    <= '0;
            bitIdx <= '0;
            phase  <= rxSync ? HUNT : BITS;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        BITS: begin
          if (cnt == BIT_LAST) begin
            cnt      <= '0;
            shiftReg <= {rxSync, shiftReg[7:1]};
            bitIdx   <= bitIdx + 3'd1;
            if (bitIdx == 3'd7) phase <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          // Back to hunting from mid-stop so the next start edge is not missed.
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            phase <= HUNT;
            if (rxSync) byte_valid_o <= 1'b1;
            else        frame_err_o  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: holds the CPU in reset, loads a word image from UART into memory, then hands over.
// Latency: each word is written 1 cycle after its 4th byte; cpu_reset_o rises 1 cycle after RUN.
// Backpressure: none; the UART cannot be stalled and CPU writes are dropped until RUN.
// Ports: clk_i, reset_i (async active-low), rxd_i; cpu (slave write port), mem (master write port);
//        cpu_reset_o, busy_o, error_o, words_loaded_o.
// Build option: define UART_BOOT_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_boot_loader
  import uart_boot_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 26,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          MAX_WORDS    = 1536,
  parameter int          BOOT_TIMEOUT = 2_000_000
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       rxd_i,
  uart_boot_loader_if.slave          cpu,
  uart_boot_loader_if.master         mem,
  output logic                       cpu_reset_o,
  output logic                       busy_o,
  output logic                       error_o,
  output logic [15:0]                words_loaded_o
);

  localparam logic [31:0] TIMEOUT_LAST = 32'(BOOT_TIMEOUT - 1);

`ifdef UART_BOOT_CHECKSUM_EN
  localparam state_t LOAD_DONE = CHK;
  logic [7:0] csum;
`else
  localparam state_t LOAD_DONE = RUN;
`endif

  state_t      state;
  logic [15:0] count;
  logic [15:0] wordsLoaded;
  logic [31:0] wordSr;
  logic [1:0]  byteIdx;
  logic [31:0] timer;
  logic        cpuResetQ;
  logic [7:0]  rxByte;
  logic        rxValid, rxFrameErr;
  logic [15:0] cntFull;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) uRx (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .rxd_i        (rxd_i),
    .byte_o       (rxByte),
    .byte_valid_o (rxValid),
    .frame_err_o  (rxFrameErr)
  );

  assign cntFull = {rxByte, count[7:0]};

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state       <= IDLE;
      count       <= '0;
      wordsLoaded <= '0;
      wordSr      <= '0;
      byteIdx     <= '0;
      timer       <= '0;
      cpuResetQ   <= 1'b0;
`ifdef UART_BOOT_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      cpuResetQ <= (state == RUN);
      if (rxFrameErr && state != IDLE && state != RUN) begin
        state <= ERROR;
      end else begin
        case (state)
          IDLE: begin
            if (rxValid && rxByte == SYNC_BYTE) state <= CNT_LO;
            else if (timer == TIMEOUT_LAST)     state <= RUN;
            else                                timer <= timer + 32'd1;
          end
          CNT_LO: begin
            if (rxValid) begin
              count[7:0] <= rxByte;
              state      <= CNT_HI;
            end
          end
          CNT_HI: begin
            if (rxValid) begin
              count[15:8] <= rxByte;
              byteIdx     <= '0;
              if (cntFull == 16'd0)                   state <= LOAD_DONE;
              else if (cntFull > 16'(MAX_WORDS))      state <= ERROR;
              else                                    state <= DATA;
            end
          end
          DATA: begin
            if (rxValid) begin
              // Little-endian: first byte ends up in bits [7:0].
              wordSr  <= {rxByte, wordSr[31:8]};
              byteIdx <= byteIdx + 2'd1;
`ifdef UART_BOOT_CHECKSUM_EN
              csum    <= csum ^ rxByte;
`endif
              if (byteIdx == 2'(WORD_BYTES - 1)) state <= WRITE;
            end
          end
          WRITE: begin
            wordsLoaded <= wordsLoaded + 16'd1;
            state       <= (wordsLoaded + 16'd1 == count) ? LOAD_DONE : DATA;
          end
`ifdef UART_BOOT_CHECKSUM_EN
          CHK: begin
            if (rxValid) state <= (rxByte == csum) ? RUN : ERROR;
          end
`endif
          default: ;  // RUN and ERROR hold until reset
        endcase
      end
    end
  end

  // Write-port mux: loader owns the port in WRITE, CPU owns it in RUN, idle otherwise.
  always_comb begin
    mem.wAddr = '0;
    mem.wData = '0;
    mem.wMask = '0;
    if (state == WRITE) begin
      mem.wAddr = BASE_ADDR + 32'(wordsLoaded) * 32'(WORD_BYTES);
      mem.wData = wordSr;
      mem.wMask = 4'b1111;
    end else if (state == RUN) begin
      mem.wAddr = cpu.wAddr;
      mem.wData = cpu.wData;
      mem.wMask = cpu.wMask;
    end
  end

  assign cpu_reset_o    = cpuResetQ;
  assign busy_o         = (state inside {CNT_LO, CNT_HI, DATA, WRITE, CHK});
  assign error_o        = (state == ERROR);
  assign words_loaded_o = wordsLoaded;

endmodule
